// File: rtl/icarus_pkg.sv
// Shared encodings for the memory/write-back datapath: load sizes,
// write-back source selects and the default link offset.
package icarus_pkg;

  localparam logic [1:0] BYTESEL_WORD = 2'b00;
  localparam logic [1:0] BYTESEL_BYTE = 2'b01;
  localparam logic [1:0] BYTESEL_HALF = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;

  localparam int LINK_OFFSET_DEFAULT = 8;

endpackage

// File: rtl/load_align.sv
// Little-endian sub-word load lane select with sign or zero extension.
// Purely combinational so the store/forwarding path can reuse it.
module load_align
  import icarus_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [1:0]            byteSel,
  input  logic                  loadSigned,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  assign byteLane = word[{offset, 3'b000} +: 8];
  // Halfword ignores offset[0]; misaligned halves are not split.
  assign halfLane = word[{offset[1], 4'b0000} +: 16];

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    data = word;
    case (byteSel)
      BYTESEL_BYTE: data = {{(DATA_WIDTH-8){loadSigned & byteLane[7]}}, byteLane};
      BYTESEL_HALF: data = {{(DATA_WIDTH-16){loadSigned & halfLane[15]}}, halfLane};
      default:      data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures memory-stage results, aligns loads,
// selects the write-back value and counts retired instructions.
module mem_wb_stage
  import icarus_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_OFFSET    = LINK_OFFSET_DEFAULT
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic [DATA_WIDTH-1:0]     ReadData,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     PC,
  input  logic [31:0]               Instruction,
  input  logic                      RegWrite,
  input  logic [1:0]                MemToReg,
  input  logic [1:0]                ByteSel,
  input  logic                      LoadSigned,
  input  logic [REG_ADDR_WIDTH-1:0] WriteReg,
  output logic [DATA_WIDTH-1:0]     WBData,
  output logic                      WBRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] WBWriteReg,
  output logic [31:0]               WBInstruction,
  output logic                      WBValid,
  output logic [31:0]               InstrCount
);

  logic [DATA_WIDTH-1:0]     readDataQ, aluResultQ, pcQ;
  logic [31:0]               instrQ;
  logic                      regWriteQ, loadSignedQ, validQ;
  logic [1:0]                memToRegQ, byteSelQ;
  logic [REG_ADDR_WIDTH-1:0] writeRegQ;
  logic [31:0]               instrCountQ;
  logic [DATA_WIDTH-1:0]     loadData;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      // A bubble zeroes data too, which keeps reset and flush identical.
      readDataQ   <= '0;
      aluResultQ  <= '0;
      pcQ         <= '0;
      instrQ      <= '0;
      regWriteQ   <= 1'b0;
      memToRegQ   <= MEMTOREG_ALU;
      byteSelQ    <= BYTESEL_WORD;
      loadSignedQ <= 1'b0;
      writeRegQ   <= '0;
      validQ      <= 1'b0;
    end else if (!Stall) begin
      readDataQ   <= ReadData;
      aluResultQ  <= ALUResult;
      pcQ         <= PC;
      instrQ      <= Instruction;
      regWriteQ   <= RegWrite;
      memToRegQ   <= MemToReg;
      byteSelQ    <= ByteSel;
      loadSignedQ <= LoadSigned;
      writeRegQ   <= WriteReg;
      validQ      <= 1'b1;
    end
  end

  // An instruction retires when it leaves WB, so a stalled one counts once.
  always_ff @(posedge Clock) begin
    if (Reset)                 instrCountQ <= '0;
    else if (!Stall && validQ) instrCountQ <= instrCountQ + 32'd1;
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .word       (readDataQ),
    .offset     (aluResultQ[1:0]),
    .byteSel    (byteSelQ),
    .loadSigned (loadSignedQ),
    .data       (loadData)
  );

  always_comb begin
    WBData = aluResultQ;
    case (memToRegQ)
      MEMTOREG_MEM:  WBData = loadData;
      MEMTOREG_LINK: WBData = pcQ + DATA_WIDTH'(LINK_OFFSET);
      default:       WBData = aluResultQ;
    endcase
  end

  assign WBRegWrite    = regWriteQ && (writeRegQ != '0);
  assign WBWriteReg    = writeRegQ;
  assign WBInstruction = instrQ;
  assign WBValid       = validQ;
  assign InstrCount    = instrCountQ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes the expected WB state
// for every edge, a monitor pops and compares one step after that edge.
module tb_mem_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Flush;
  logic [31:0] ReadData, ALUResult, PC, Instruction;
  logic        RegWrite, LoadSigned;
  logic [1:0]  MemToReg, ByteSel;
  logic [4:0]  WriteReg;
  logic [31:0] WBData, WBInstruction, InstrCount;
  logic        WBRegWrite, WBValid;
  logic [4:0]  WBWriteReg;

  mem_wb_stage dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ReadData(ReadData), .ALUResult(ALUResult), .PC(PC), .Instruction(Instruction),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ByteSel(ByteSel),
    .LoadSigned(LoadSigned), .WriteReg(WriteReg),
    .WBData(WBData), .WBRegWrite(WBRegWrite), .WBWriteReg(WBWriteReg),
    .WBInstruction(WBInstruction), .WBValid(WBValid), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          rst, stall, flush;
    logic [31:0] rd, alu, pc, ins;
    bit          rw, sgn;
    logic [1:0]  m2r, bs;
    logic [4:0]  wr;
  } in_t;

  typedef struct {
    logic [31:0] data, instr, count;
    logic        regWrite, valid;
    logic [4:0]  writeReg;
    bit          dataCare;
  } exp_t;

  exp_t sbQ[$];
  exp_t prev;
  int   tests = 0;
  int   failures = 0;

  // Reference load: shift the addressed lane down, mask, then extend.
  function automatic logic [31:0] refLoad(logic [31:0] w, logic [1:0] off,
                                          logic [1:0] bs, bit sgn);
    logic [31:0] v;
    if (bs == 2'b01) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (bs == 2'b10) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic in_t idle();
    in_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic in_t rnd();
    in_t s;
    s.rst   = ($urandom_range(0, 99) < 3);
    s.stall = ($urandom_range(0, 99) < 15);
    s.flush = ($urandom_range(0, 99) < 10);
    s.rd = $urandom; s.alu = $urandom; s.pc = $urandom; s.ins = $urandom;
    s.rw = $urandom_range(0, 1); s.sgn = $urandom_range(0, 1);
    s.m2r = 2'($urandom_range(0, 3)); s.bs = 2'($urandom_range(0, 3));
    s.wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    return s;
  endfunction

  // Apply inputs for the coming edge, predict the state after it, wait a cycle.
  task automatic step(input in_t s);
    exp_t n;
    Reset = s.rst; Stall = s.stall; Flush = s.flush;
    ReadData = s.rd; ALUResult = s.alu; PC = s.pc; Instruction = s.ins;
    RegWrite = s.rw; LoadSigned = s.sgn; MemToReg = s.m2r; ByteSel = s.bs;
    WriteReg = s.wr;
    if (s.rst) begin
      n = '{data: 0, instr: 0, count: 0, regWrite: 0, valid: 0, writeReg: 0, dataCare: 1};
    end else begin
      n = prev;
      if (!s.stall && prev.valid) n.count = prev.count + 1;
      if (s.flush) begin
        n.regWrite = 0; n.instr = 0; n.valid = 0; n.dataCare = 0;
      end else if (!s.stall) begin
        n.valid    = 1;
        n.dataCare = 1;
        n.instr    = s.ins;
        n.writeReg = s.wr;
        n.regWrite = s.rw && (s.wr != 0);
        case (s.m2r)
          2'b01:   n.data = refLoad(s.rd, s.alu[1:0], s.bs, s.sgn);
          2'b10:   n.data = s.pc + 32'd8;
          default: n.data = s.alu;
        endcase
      end
    end
    prev = n;
    sbQ.push_back(n);
    @(negedge Clock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        tests++;
        if ((e.dataCare && (WBData !== e.data || WBWriteReg !== e.writeReg)) ||
            WBRegWrite !== e.regWrite || WBInstruction !== e.instr ||
            WBValid !== e.valid || InstrCount !== e.count) begin
          failures++;
          $display("FAIL wb_out t=%0t: got data=%h rw=%b wr=%0d ins=%h v=%b cnt=%h; expected data=%h(care=%0d) rw=%b wr=%0d ins=%h v=%b cnt=%h",
                   $time, WBData, WBRegWrite, WBWriteReg, WBInstruction, WBValid, InstrCount,
                   e.data, e.dataCare, e.regWrite, e.writeReg, e.instr, e.valid, e.count);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : driver
    in_t s;
    prev = '{data: 0, instr: 0, count: 0, regWrite: 0, valid: 0, writeReg: 0, dataCare: 1};
    s = idle(); s.rst = 1;
    step(s);
    step(s);

    // Byte and halfword loads of 0x80FF7F01 at various lanes.
    s = idle(); s.rd = 32'h80FF_7F01; s.m2r = 2'b01; s.rw = 1; s.wr = 5'd5;
    s.bs = 2'b01; s.alu = 32'h0000_1003; s.sgn = 1; s.ins = 32'h0030_0283; step(s);
    s.sgn = 0; s.ins = 32'h0030_4283; step(s);
    s.alu = 32'h0000_1001; step(s);
    s.bs = 2'b10; s.alu = 32'h0000_1002; s.sgn = 1; s.ins = 32'h0020_1283; step(s);
    s.alu = 32'h0000_1000; s.sgn = 0; s.ins = 32'h0000_5283; step(s);
    s.bs = 2'b11; s.alu = 32'h0000_1003; step(s);

    // Link write-back and the $0 suppression.
    s = idle(); s.m2r = 2'b10; s.pc = 32'h0040_0010; s.wr = 5'd31; s.rw = 1;
    s.ins = 32'h0080_00EF; step(s);
    s.wr = 5'd0; s.m2r = 2'b00; s.alu = 32'h1234_5678; step(s);
    s.m2r = 2'b11; s.wr = 5'd7; step(s);

    // Reset in the middle of a stream of valid loads.
    s = rnd(); s.rst = 0; s.stall = 0; s.flush = 0; step(s); step(s);
    s.rst = 1; step(s);
    s.rst = 0; s.ins = 32'hDEAD_BEEF; step(s);

    // Three stalled cycles with changing inputs, then Flush with Stall.
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.rst = 0; s.stall = 1; s.flush = 0; step(s);
    end
    s = rnd(); s.rst = 0; s.stall = 1; s.flush = 1; s.rw = 1; s.wr = 5'd9; step(s);
    s = rnd(); s.rst = 0; s.stall = 0; s.flush = 0; step(s);

    // Counter wrap: hold the entry, preload the counter, retire once.
    s.stall = 1; step(s);
    force dut.instrCountQ = 32'hFFFF_FFFF;
    #1;
    release dut.instrCountQ;
    prev.count = 32'hFFFF_FFFF;
    s.stall = 0; step(s);
    step(s);

    for (int i = 0; i < 400; i++) step(rnd());

    s = idle(); step(s);
    @(negedge Clock);
    tests++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
